// File: rtl/stack_ctrl_pkg.sv
// rtl/stack_ctrl_pkg.sv - shared opcode, error and state types for the stack command sequencer
package stack_ctrl_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_DUP     = 3'd4,
        OP_SWAP    = 3'd5,
        OP_DROPN   = 3'd6,
        OP_RSVD    = 3'd7
    } op_t;

    // Rejection reasons reported on err_code alongside the err pulse.
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_ILLEGAL   = 2'd3
    } err_t;

    // Sequencer states; only ST_IDLE accepts commands.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC1 = 3'd1,
        ST_SWAP1 = 3'd2,
        ST_SWAP2 = 3'd3,
        ST_SWAP3 = 3'd4,
        ST_DROP  = 3'd5
    } state_t;

endpackage

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - expands stack commands into per-cycle push/pop/insert strobes
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; ready only while idle
//   cmd_op/cmd_data/cmd_count  opcode, immediate for PUSH/REPLACE, count for DROPN
//   done, err, err_code     one-cycle completion / rejection pulses
//   depth                   current stack occupancy, 0..DEPTH
//   stk_push/stk_pop/stk_insert  strobes and data to the stack
//   stk_tops                stack top (low WIDTH bits) and second element (high WIDTH bits)
module stack_sequencer
    import stack_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [CNT_W-1:0]   cmd_count,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   depth,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [WIDTH-1:0]   stk_insert,
    input  logic [2*WIDTH-1:0] stk_tops
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic              ready_q;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic [WIDTH-1:0]  insert_q, insert_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_t              code_q, code_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    op_t               op;
    err_t              rej;

    assign op = op_t'(cmd_op);

    // Rejection is judged against the occupancy visible at acceptance; the
    // previous command's last strobe has already been folded into depth_q.
    always_comb begin
        rej = ERR_NONE;
        if ((op == OP_PUSH || op == OP_DUP) && depth_q == DEPTH_C) begin
            rej = ERR_OVERFLOW;
        end else if (((op == OP_POP || op == OP_REPLACE || op == OP_DUP) && depth_q == '0) ||
                     (op == OP_SWAP && depth_q < TWO_C) ||
                     (op == OP_DROPN && cmd_count > depth_q)) begin
            rej = ERR_UNDERFLOW;
        end else if (op == OP_RSVD) begin
            rej = ERR_ILLEGAL;
        end
    end

    // Occupancy follows the strobes actually presented to the stack, so it
    // changes at the end of each strobe cycle. Replace (push+pop) is net zero.
    always_comb begin
        depth_d = depth_q;
        case ({push_q, pop_q})
            2'b10:   depth_d = depth_q + ONE_C;
            2'b01:   depth_d = depth_q - ONE_C;
            default: depth_d = depth_q;
        endcase
    end

    // State register; outputs are registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            depth_q  <= '0;
            ready_q  <= 1'b1;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            insert_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            ready_q  <= (state_d == ST_IDLE);
            push_q   <= push_d;
            pop_q    <= pop_d;
            insert_q <= insert_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (rej != ERR_NONE) begin
                        state_d = ST_EXEC1;
                    end else begin
                        case (op)
                            OP_SWAP:  state_d = ST_SWAP1;
                            OP_DROPN: state_d = ST_DROP;
                            default:  state_d = ST_EXEC1;
                        endcase
                    end
                end
            end
            ST_EXEC1: state_d = ST_IDLE;
            ST_SWAP1: state_d = ST_SWAP2;
            ST_SWAP2: state_d = ST_SWAP3;
            ST_SWAP3: state_d = ST_IDLE;
            // cnt_q counts the pops still to be presented, including the one
            // on the outputs now; leave when that is the last (or there were none).
            ST_DROP:  if (cnt_q <= ONE_C) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: computes what the registered outputs show next cycle.
    always_comb begin
        push_d   = 1'b0;
        pop_d    = 1'b0;
        insert_d = insert_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = ERR_NONE;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (rej != ERR_NONE) begin
                        err_d  = 1'b1;
                        code_d = rej;
                    end else begin
                        case (op)
                            OP_NOP: begin
                                done_d = 1'b1;
                            end
                            OP_PUSH: begin
                                push_d   = 1'b1;
                                insert_d = cmd_data;
                                done_d   = 1'b1;
                            end
                            OP_POP: begin
                                pop_d  = 1'b1;
                                done_d = 1'b1;
                            end
                            OP_REPLACE: begin
                                push_d   = 1'b1;
                                pop_d    = 1'b1;
                                insert_d = cmd_data;
                                done_d   = 1'b1;
                            end
                            OP_DUP: begin
                                push_d   = 1'b1;
                                insert_d = stk_tops[WIDTH-1:0];
                                done_d   = 1'b1;
                            end
                            OP_SWAP: begin
                                // Both elements are captured now because the
                                // stack contents change under us from T+1 on.
                                a_d   = stk_tops[WIDTH-1:0];
                                b_d   = stk_tops[2*WIDTH-1:WIDTH];
                                pop_d = 1'b1;
                            end
                            OP_DROPN: begin
                                cnt_d = cmd_count;
                                if (cmd_count == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    pop_d  = 1'b1;
                                    done_d = (cmd_count == ONE_C);
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
            ST_SWAP1: begin
                // Replace the exposed second element with the old top.
                push_d   = 1'b1;
                pop_d    = 1'b1;
                insert_d = a_q;
            end
            ST_SWAP2: begin
                push_d   = 1'b1;
                insert_d = b_q;
                done_d   = 1'b1;
            end
            ST_DROP: begin
                if (cnt_q > ONE_C) begin
                    pop_d  = 1'b1;
                    cnt_d  = cnt_q - ONE_C;
                    done_d = (cnt_q == TWO_C);
                end
            end
            default: begin
            end
        endcase
    end

    assign cmd_ready  = ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign depth      = depth_q;
    assign stk_push   = push_q;
    assign stk_pop    = pop_q;
    assign stk_insert = insert_q;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Command front-end for the on-chip register stack (push/pop/insert/tops primitive, one op per cycle, replace-on-push+pop).
- Accepts multi-step stack commands over a valid/ready handshake and expands them into per-cycle push/pop/insert strobes.
- Tracks stack occupancy and rejects overflow/underflow before touching the stack.
- Sits between the core0 decode stage and the data stack instance, which is built with VISIBLES >= 2.

Parameters:
- WIDTH, 32, stack element width.
- DEPTH, 16, stack depth in entries; must match the stack instance; minimum 2.
- CNT_W, 5, width of cmd_count and depth; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  opcode (stack_ctrl_pkg::op_t).
- cmd_data  in  WIDTH  immediate for PUSH/REPLACE.
- cmd_count  in  CNT_W  element count for DROPN.
- done  out  1  one-cycle pulse when a command completes successfully.
- err  out  1  one-cycle pulse when a command is rejected.
- err_code  out  2  valid with err (stack_ctrl_pkg::err_t).
- depth  out  CNT_W  current occupancy, 0..DEPTH.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_insert  out  WIDTH  to stack insert.
- stk_tops  in  2*WIDTH  stack tops; [0] is the top, [1] is second.

Behaviour:
- Reset, asynchronous: state=IDLE, depth=0, cmd_ready=1, and done, err, err_code, stk_push, stk_pop, stk_insert all 0. Reset mid-command aborts it immediately; no further strobes are issued.
- All outputs are registered. Acceptance cycle is T. The first strobe, err or done appears in T+1.
- Opcodes:
  - NOP=0: done in T+1.
  - PUSH=1: push cmd_data in T+1; depth+1.
  - POP=2: pop in T+1; depth-1.
  - REPLACE=3: push+pop with cmd_data in T+1; depth unchanged.
  - DUP=4: push of stk_tops[0] (latched at T) in T+1; depth+1.
  - SWAP=5: latch a=stk_tops[0], b=stk_tops[1] at T.
    - T+1: pop.
    - T+2: push+pop, insert a.
    - T+3: push, insert b.
    - done in T+3; depth unchanged net.
  - DROPN=6: n=cmd_count latched at T.
    - Pops in T+1..T+n; done in T+n; depth-n.
    - n=0: no strobes; done in T+1.
  - 7: reserved.
- done is asserted in the same cycle as the final strobe. depth updates at the end of each strobe cycle.
- Rejection is checked at T against the current depth. On rejection: no strobes, err pulses in T+1, no done, depth unchanged.
  - OVERFLOW=1: PUSH or DUP with depth==DEPTH.
  - UNDERFLOW=2: POP, REPLACE or DUP with depth==0; SWAP with depth<2; DROPN with n>depth.
  - ILLEGAL=3: op 7.
  - Checks are in the order listed; the first match wins.
- FSM states:
  - IDLE: ready. Goes to EXEC1 for single-step ops, NOP and rejects; SWAP1 for SWAP; DROP for DROPN.
  - EXEC1 → IDLE.
  - SWAP1 → SWAP2 → SWAP3 → IDLE.
  - DROP: loop with a down-counter; → IDLE in the cycle the last pop issues, or immediately for n=0.
- cmd_ready=0 in every non-IDLE state, so the maximum rate is one command per 2 cycles.
- stk_push and stk_pop are never asserted while in IDLE. stk_insert holds its last value when unused; don't-care to the stack.
- depth never leaves [0, DEPTH]; an assertion in the bench checks this.

Decomposition:
- Package stack_ctrl_pkg:
  - op_t enum (3 bits).
  - err_t enum: NONE, OVERFLOW, UNDERFLOW, ILLEGAL.
  - state_t enum.
- No sub-module: the occupancy counter and FSM live in one module, roughly 180 lines.
- Bench instantiates stack_sequencer with a stack of matching DEPTH and VISIBLES=2.

Test Plan:
- WIDTH=32, DEPTH=4. PUSH 0x11, 0x22, 0x33 → depth=3, tops={0x33,0x22}, three done pulses, each one cycle after acceptance.
- From {0x33,0x22,0x11}: SWAP → strobes pop, push+pop(0x33), push(0x22) in T+1..T+3; done in T+3; tops={0x22,0x33}; depth=3.
- Depth=3: DUP → depth=4, tops={0x22,0x22}. Then PUSH 0x44 → err, err_code=OVERFLOW, no strobes, depth=4.
- Depth=4: DROPN 3 → pops in T+1..T+3, done in T+3, depth=1. DROPN 2 → err UNDERFLOW. DROPN 0 → done in T+1, no strobes.
- Depth=0: POP, REPLACE and SWAP each → err UNDERFLOW. Op 7 → err ILLEGAL. cmd_ready stays high throughout IDLE.
- Assert reset_n low in SWAP2 → all strobes drop immediately; after release, depth=0 and cmd_ready=1; a following PUSH works normally.
